// File: rtl/systolic_n_body_2x2_scheduler.sv
// Timestep sequencer for the 2x2 systolic n-body array: CLEAR -> FEED -> DRAIN -> INTEG per step.
// Optional run abort (abort/aborted ports) is compiled in with `define SNBODY_SCHED_ABORT_EN.
module systolic_n_body_2x2_scheduler #(
    parameter int N_BODIES  = 2,
    parameter int ARRAY_DIM = 2,
    parameter int PIPE_LAT  = 2,
    parameter int STEP_W    = 16,
    parameter int CW        = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [STEP_W-1:0] num_steps,
    input  logic              stall,
`ifdef SNBODY_SCHED_ABORT_EN
    input  logic              abort,
    output logic              aborted,
`endif
    output logic              cell_reset,
    output logic              feed_en,
    output logic [CW-1:0]     feed_cycle,
    output logic              integ_en,
    output logic [CW-1:0]     integ_body,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] step_cnt
);

    localparam logic [CW-1:0] FEED_LAST  = CW'(2*ARRAY_DIM-2);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(PIPE_LAT-1);
    localparam logic [CW-1:0] INTEG_LAST = CW'(N_BODIES-1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_INTEG,
        S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     phase_reg, phase_next;
    logic [STEP_W-1:0] step_reg, step_next;
    logic [STEP_W-1:0] nsteps_reg, nsteps_next;
    logic [STEP_W-1:0] step_inc;
    logic              busy_state;
    logic              abort_req;
    logic              abort_hit;

`ifdef SNBODY_SCHED_ABORT_EN
    logic aborted_reg;

    assign abort_req = abort;
    assign aborted   = aborted_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            aborted_reg <= 1'b0;
        end else begin
            aborted_reg <= abort_hit;
        end
    end
`else
    assign abort_req = 1'b0;
`endif

    assign step_inc   = step_reg + STEP_W'(1);
    assign busy_state = (state_reg == S_CLEAR) || (state_reg == S_FEED) ||
                        (state_reg == S_DRAIN) || (state_reg == S_INTEG);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            phase_reg  <= '0;
            step_reg   <= '0;
            nsteps_reg <= '0;
        end else begin
            state_reg  <= state_next;
            phase_reg  <= phase_next;
            step_reg   <= step_next;
            nsteps_reg <= nsteps_next;
        end
    end

    // A stalled busy cycle leaves every register untouched, so the same slot is replayed.
    always_comb begin
        state_next  = state_reg;
        phase_next  = phase_reg;
        step_next   = step_reg;
        nsteps_next = nsteps_reg;
        abort_hit   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    nsteps_next = num_steps;
                    step_next   = '0;
                    phase_next  = '0;
                    state_next  = (num_steps == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (!stall) begin
                    state_next = S_FEED;
                    phase_next = '0;
                end
            end
            S_FEED: begin
                if (!stall) begin
                    if (phase_reg == FEED_LAST) begin
                        state_next = S_DRAIN;
                        phase_next = '0;
                    end else begin
                        phase_next = phase_reg + CW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (!stall) begin
                    if (phase_reg == DRAIN_LAST) begin
                        state_next = S_INTEG;
                        phase_next = '0;
                    end else begin
                        phase_next = phase_reg + CW'(1);
                    end
                end
            end
            S_INTEG: begin
                if (!stall) begin
                    if (phase_reg == INTEG_LAST) begin
                        step_next  = step_inc;
                        phase_next = '0;
                        state_next = (step_inc == nsteps_reg) ? S_DONE : S_CLEAR;
                    end else begin
                        phase_next = phase_reg + CW'(1);
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
                phase_next = '0;
            end
            default: begin
                state_next = S_IDLE;
                phase_next = '0;
            end
        endcase

        // Abort outranks stall and discards the partially completed step.
        if (busy_state && abort_req) begin
            state_next = S_DONE;
            phase_next = '0;
            step_next  = step_reg;
            abort_hit  = 1'b1;
        end
    end

    assign busy       = busy_state;
    assign done       = (state_reg == S_DONE);
    assign cell_reset = (state_reg == S_CLEAR) && !stall;
    assign feed_en    = (state_reg == S_FEED) && !stall;
    assign integ_en   = (state_reg == S_INTEG) && !stall;
    assign feed_cycle = (state_reg == S_FEED) ? phase_reg : '0;
    assign integ_body = (state_reg == S_INTEG) ? phase_reg : '0;
    assign step_cnt   = step_reg;

endmodule

// File: tb/tb_systolic_n_body_2x2_scheduler.sv
// Self-checking bench for systolic_n_body_2x2_scheduler: directed runs plus randomized runs with
// random stall/restart/reset, checked every cycle against a slot-queue model of one timestep.
module tb_systolic_n_body_2x2_scheduler;

    localparam int STEP_W   = 16;
    localparam int CW       = 3;
    localparam int FEED_LEN = 3;
    localparam int DRAIN    = 2;
    localparam int BODIES   = 2;

    logic              clk = 1'b0;
    logic              reset, start, stall, abort, aborted;
    logic [STEP_W-1:0] num_steps;
    logic              cell_reset, feed_en, integ_en, busy, done;
    logic [CW-1:0]     feed_cycle, integ_body;
    logic [STEP_W-1:0] step_cnt;

    int errors = 0;
    int checks = 0;

    // Model: one queue entry per busy cycle; code = kind*100 + index*10 + last_of_step.
    // kind 0=clear, 1=feed, 2=drain, 3=integ.
    int mq[$];
    bit m_done, m_abort;
    int m_step;

    always #5 clk = ~clk;

    systolic_n_body_2x2_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_steps  (num_steps),
        .stall      (stall),
`ifdef SNBODY_SCHED_ABORT_EN
        .abort      (abort),
        .aborted    (aborted),
`endif
        .cell_reset (cell_reset),
        .feed_en    (feed_en),
        .feed_cycle (feed_cycle),
        .integ_en   (integ_en),
        .integ_body (integ_body),
        .busy       (busy),
        .done       (done),
        .step_cnt   (step_cnt)
    );

`ifndef SNBODY_SCHED_ABORT_EN
    assign aborted = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic do_cycle(input bit st, input bit sl, input bit rs, input bit ab,
                            input int n, output int b);
        int kind, idx;
        bit e_cr, e_fe, e_ie, e_busy, e_done, e_ab;
        int e_fc, e_ib;
        start = st; stall = sl; reset = rs; abort = ab;
        num_steps = n[STEP_W-1:0];
        #1;
        e_cr = 0; e_fe = 0; e_ie = 0; e_busy = 0; e_done = 0; e_fc = 0; e_ib = 0;
        if (mq.size() > 0) begin
            kind   = mq[0] / 100;
            idx    = (mq[0] / 10) % 10;
            e_busy = 1;
            e_cr   = (kind == 0) && !sl;
            e_fe   = (kind == 1) && !sl;
            e_ie   = (kind == 3) && !sl;
            e_fc   = (kind == 1) ? idx : 0;
            e_ib   = (kind == 3) ? idx : 0;
        end else if (m_done) begin
            e_done = 1;
        end
        e_ab = m_done && m_abort;
        chk("cell_reset", cell_reset, e_cr);
        chk("feed_en", feed_en, e_fe);
        chk("feed_cycle", feed_cycle, e_fc);
        chk("integ_en", integ_en, e_ie);
        chk("integ_body", integ_body, e_ib);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("step_cnt", step_cnt, m_step);
        chk("aborted", aborted, e_ab);
        $display("cyc st=%0d sl=%0d rs=%0d ab=%0d busy=%0d cr=%0d fe=%0d fc=%0d ie=%0d ib=%0d done=%0d steps=%0d",
                 st, sl, rs, ab, busy, cell_reset, feed_en, feed_cycle, integ_en, integ_body, done, step_cnt);
        b = int'(busy);
        @(posedge clk);
        #1;
        if (rs) begin
            mq.delete(); m_done = 0; m_abort = 0; m_step = 0;
        end else if (mq.size() > 0) begin
            if (ab) begin
                mq.delete(); m_done = 1; m_abort = 1;
            end else if (!sl) begin
                if (mq[0] % 10 == 1) m_step++;
                void'(mq.pop_front());
                if (mq.size() == 0) m_done = 1;
            end
        end else if (m_done) begin
            m_done = 0; m_abort = 0;
        end else if (st) begin
            m_step = 0;
            for (int s = 0; s < n; s++) begin
                mq.push_back(0);
                for (int i = 0; i < FEED_LEN; i++) mq.push_back(100 + i*10);
                for (int i = 0; i < DRAIN; i++) mq.push_back(200 + i*10);
                for (int i = 0; i < BODIES; i++) mq.push_back(300 + i*10 + ((i == BODIES-1) ? 1 : 0));
            end
            if (n == 0) m_done = 1;
        end
    endtask

    task automatic run(input string name, input int n, input bit [63:0] stall_mask,
                       input int reset_at, input int restart_at, input int abort_at,
                       output int busy_cycles);
        int c, b;
        bit sl;
        c = 0;
        busy_cycles = 0;
        do begin
            sl = (c < 64) ? stall_mask[c] : 1'b0;
            do_cycle((c == 0) || (c == restart_at), sl, c == reset_at, c == abort_at, n, b);
            busy_cycles += b;
            c++;
        end while ((mq.size() > 0 || m_done) && c < 300);
        chk({name, "_bound"}, (c < 300) ? 1 : 0, 1);
        $display("run %s n=%0d busy_cycles=%0d final_steps=%0d", name, n, busy_cycles, step_cnt);
    endtask

    initial begin
        int b, n, rst_at;
        bit [63:0] mask;
        reset = 1; start = 0; stall = 0; abort = 0; num_steps = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        mq.delete(); m_done = 0; m_abort = 0; m_step = 0;

        run("t1_single", 1, 64'd0, -1, -1, -1, b);
        chk("t1_busy_len", b, 8);
        run("t2_three", 3, 64'd0, -1, -1, -1, b);
        chk("t2_busy_len", b, 24);
        run("t3_zero", 0, 64'd0, -1, -1, -1, b);
        chk("t3_busy_len", b, 0);
        run("t4_stall", 1, 64'h18, -1, -1, -1, b);
        chk("t4_busy_len", b, 10);
        run("t5_reset", 2, 64'd0, 5, 2, -1, b);
        chk("t5_busy_len", b, 5);
`ifdef SNBODY_SCHED_ABORT_EN
        run("t6_abort", 4, 64'd0, -1, -1, 10, b);
        chk("t6_busy_len", b, 10);
`endif
        for (int r = 0; r < 20; r++) begin
            n      = int'($urandom_range(0, 3));
            mask   = {$urandom, $urandom} & {$urandom, $urandom};
            rst_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 30)) : -1;
            run("rand", n, mask, rst_at, int'($urandom_range(1, 20)), -1, b);
        end
        do_cycle(0, 0, 0, 0, 0, b);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
